// File: rtl/decode_pkg.sv
// Shared decode definitions: control bundle layout, encodings and the
// pure instruction-to-control decode function.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_R_I    = 2'd2;

    localparam logic [1:0] RESSRC_ALU = 2'd0;
    localparam logic [1:0] RESSRC_MEM = 2'd1;
    localparam logic [1:0] RESSRC_PC4 = 2'd2;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] imm_sel;
        logic       is_u_type;
        logic [1:0] alu_op_type;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       is_mul;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr, input logic support_m);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3            = instr[14:12];
        f7            = instr[31:25];
        c             = '0;
        c.result_src  = RESSRC_ALU;
        c.imm_sel     = IMM_I;
        c.alu_op_type = ALUOP_R_I;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                c.reg_write = 1'b1; c.alu_src = 1'b1; c.is_u_type = 1'b1;
                c.alu_op_type = ALUOP_ADD;
            end
            OPC_JAL: begin
                c.reg_write = 1'b1; c.result_src = RESSRC_PC4; c.jump = 1'b1;
                c.imm_sel = IMM_J;
            end
            OPC_JALR: begin
                if (f3 == 3'd0) begin
                    c.reg_write = 1'b1; c.result_src = RESSRC_PC4; c.jump = 1'b1;
                    c.alu_src = 1'b1; c.alu_op_type = ALUOP_ADD;
                end else c.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                if (f3 != 3'd2 && f3 != 3'd3) begin
                    c.branch = 1'b1; c.imm_sel = IMM_B; c.alu_op_type = ALUOP_BRANCH;
                end else c.illegal = 1'b1;
            end
            OPC_LOAD: begin
                if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
                    c.reg_write = 1'b1; c.result_src = RESSRC_MEM; c.alu_src = 1'b1;
                    c.alu_op_type = ALUOP_ADD; c.mem_size = f3[1:0]; c.mem_unsigned = f3[2];
                end else c.illegal = 1'b1;
            end
            OPC_STORE: begin
                if (f3 <= 3'd2) begin
                    c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_S;
                    c.alu_op_type = ALUOP_ADD; c.mem_size = f3[1:0];
                end else c.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                c.reg_write = 1'b1; c.alu_src = 1'b1;
            end
            OPC_OP: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) c.reg_write = 1'b1;
                else if (f7 == 7'b0000001 && support_m) begin
                    c.reg_write = 1'b1; c.is_mul = 1'b1;
                end else c.illegal = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        // Illegal entries carry only the default bundle so no side effect can leak downstream.
        if (c.illegal) begin
            c             = '0;
            c.alu_op_type = ALUOP_R_I;
            c.illegal     = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH valid/ready FIFO with synchronous flush.
// Handshake: a beat transfers on an edge where valid & ready; valid never waits on ready.
module decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count != FULL_CNT);
    assign out_valid_o = (count != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem[wr_ptr] <= in_data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: decodes at accept time, buffers {ctrl, instr, pc} in a FIFO
// and keeps a saturating count of accepted illegal instructions.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter int SUPPORT_M = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output ctrl_t            out_ctrl_o,
    output logic [31:0]      out_instr_o,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);
    localparam int ENTRY_W = $bits(ctrl_t) + 32 + XLEN;

    ctrl_t              dec_ctrl;
    logic [ENTRY_W-1:0] fifo_out;
    logic               accept;

    assign dec_ctrl = decode_ctrl(instr_i, SUPPORT_M != 0);
    assign accept   = in_valid_i & in_ready_o & ~flush_i;

    decode_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   ({dec_ctrl, instr_i, pc_i}),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (fifo_out)
    );

    assign {out_ctrl_o, out_instr_o, out_pc_o} = fifo_out;

    // Flush clears buffered work but not the illegal history.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            illegal_cnt_o <= '0;
        end else if (accept && dec_ctrl.illegal && (illegal_cnt_o != '1)) begin
            illegal_cnt_o <= illegal_cnt_o + 1'b1;
        end
    end

endmodule
